mips_mmio_responder: RTL and testbench

- Memory-mapped I/O slave answering the MIPS core's data-side bus (Address/WriteData/MemWrite/MemRead).
- It owns the processor's PortOut register and samples the external PortIn byte through a synchronizer.
- It also provides a reload down-counter timer, sticky event flags and an interrupt line.
- It sits beside DataMemory. The core's writeback mux selects this block's ReadData when Hit=1.

---
 rtl/mips_mmio_responder_if.sv | 15 +
 rtl/mips_mmio_responder.sv | 96 +++++++++
 tb/tb_mips_mmio_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mips_mmio_responder_if.sv
// Data-side load/store bus between the MIPS core and memory-mapped slaves.
// Combinational response: ReadData/Hit are valid in the same cycle as the request.
interface mips_mmio_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (output Address, WriteData, MemWrite, MemRead,
                    input  ReadData, Hit);
    modport slave  (input  Address, WriteData, MemWrite, MemRead,
                    output ReadData, Hit);
endinterface

// File: rtl/mips_mmio_responder.sv
// MMIO slave beside DataMemory: output port, synchronized input port,
// reload down-counter timer, W1C event flags and a level interrupt.
module mips_mmio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_mmio_responder_if.slave  bus,
    input  logic [IN_WIDTH-1:0]   PortIn,
    output logic [31:0]           PortOut,
    output logic                  Irq
);
    localparam logic [2:0] OFF_PORT_OUT = 3'd0;
    localparam logic [2:0] OFF_PORT_IN  = 3'd1;
    localparam logic [2:0] OFF_STATUS   = 3'd2;
    localparam logic [2:0] OFF_LOAD     = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_COUNT    = 3'd5;

    logic [31:0]         r_port_out;
    logic [IN_WIDTH-1:0] r_sync1, r_sync2, r_prev;
    logic                r_in_chg, r_tick;
    logic [31:0]         r_load;
    logic [2:0]          r_ctrl;
    logic [31:0]         r_count;

    logic [2:0]  w_off;
    logic        w_valid;
    logic        w_wr;
    logic        w_ten_rise;
    logic        w_tick_set;
    logic        w_chg_set;
    logic [1:0]  w_clr;
    logic [31:0] w_rdata;

    assign w_off   = bus.Address[4:2];
    assign w_valid = (bus.Address[31:5] == BASE_ADDR[31:5]) &&
                     (bus.Address[1:0] == 2'b00) && (w_off <= OFF_COUNT);
    assign bus.Hit = w_valid && (bus.MemRead || bus.MemWrite);
    assign w_wr    = bus.Hit && bus.MemWrite;

    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            OFF_PORT_OUT: w_rdata = r_port_out;
            OFF_PORT_IN:  w_rdata = 32'(r_sync2);
            OFF_STATUS:   w_rdata = {30'h0, r_tick, r_in_chg};
            OFF_LOAD:     w_rdata = r_load;
            OFF_CTRL:     w_rdata = {29'h0, r_ctrl};
            OFF_COUNT:    w_rdata = r_count;
            default:      w_rdata = 32'h0;
        endcase
    end
    assign bus.ReadData = bus.Hit ? w_rdata : 32'h0;

    // Hardware set is OR'd in after the clear mask, so a same-cycle set wins.
    assign w_clr      = (w_wr && w_off == OFF_STATUS) ? bus.WriteData[1:0] : 2'b00;
    assign w_chg_set  = (r_sync2 != r_prev);
    assign w_ten_rise = w_wr && (w_off == OFF_CTRL) && bus.WriteData[0] && !r_ctrl[0];
    assign w_tick_set = r_ctrl[0] && (r_count == 32'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_port_out <= 32'h0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_in_chg   <= 1'b0;
            r_tick     <= 1'b0;
            r_load     <= 32'h0;
            r_ctrl     <= 3'h0;
            r_count    <= 32'h0;
        end else begin
            r_sync1 <= PortIn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            if (w_wr && w_off == OFF_PORT_OUT) r_port_out <= bus.WriteData;
            if (w_wr && w_off == OFF_LOAD)     r_load     <= bus.WriteData;
            if (w_wr && w_off == OFF_CTRL)     r_ctrl     <= bus.WriteData[2:0];

            r_in_chg <= w_chg_set  | (r_in_chg & ~w_clr[0]);
            r_tick   <= w_tick_set | (r_tick   & ~w_clr[1]);

            // Enabling the timer primes COUNT from LOAD; LOAD writes only land at reload.
            if (w_ten_rise)
                r_count <= r_load;
            else if (r_ctrl[0])
                r_count <= (r_count == 32'h0) ? r_load : r_count - 32'h1;
        end
    end

    assign PortOut = r_port_out;
    assign Irq     = (r_in_chg & r_ctrl[1]) | (r_tick & r_ctrl[2]);
endmodule

// File: tb/tb_mips_mmio_responder.sv
// Directed bench for mips_mmio_responder: inputs change on negedge, outputs sampled before posedge.
module tb_mips_mmio_responder;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        Irq;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rv;

    mips_mmio_responder_if bus ();

    mips_mmio_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .PortIn  (PortIn),
        .PortOut (PortOut),
        .Irq     (Irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.Address  = 32'h0;
        bus.WriteData = 32'h0;
    endtask

    // Store spanning one rising edge; returns at the following negedge.
    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        bus.Address   = BASE + off;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        bus.MemRead   = 1'b0;
        @(negedge clk);
        idle();
    endtask

    // Combinational load in the current cycle, no clock advance.
    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        bus.Address = BASE + off;
        bus.MemRead = 1'b1;
        #1 d = bus.ReadData;
        idle();
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle();
        PortIn = 8'h00;
        reset  = 1'b1;
        cyc(2);
        reset = 1'b0;

        // Reset state: every register reads 0 and decodes
        for (int i = 0; i < 6; i++) begin
            bus.Address = BASE + 32'(i * 4);
            bus.MemRead = 1'b1;
            #1;
            chk($sformatf("rst_rd%0d", i), bus.ReadData, 32'h0);
            chk($sformatf("rst_hit%0d", i), {31'h0, bus.Hit}, 32'h1);
        end
        idle();
        chk("rst_portout", PortOut, 32'h0);
        chk("rst_irq", {31'h0, Irq}, 32'h0);
        bus.Address = BASE + 32'h18; bus.MemRead = 1'b1; #1;
        chk("undef_hit", {31'h0, bus.Hit}, 32'h0);
        bus.Address = BASE + 32'h20; #1;
        chk("outside_hit", {31'h0, bus.Hit}, 32'h0);
        chk("outside_rd", bus.ReadData, 32'h0);
        bus.Address = BASE; bus.MemRead = 1'b0; #1;
        chk("nostrobe_hit", {31'h0, bus.Hit}, 32'h0);
        idle();

        // Same-cycle write+read returns pre-write value
        @(negedge clk);
        bus.Address = BASE; bus.WriteData = 32'hDEADBEEF;
        bus.MemWrite = 1'b1; bus.MemRead = 1'b1; #1;
        chk("wr_rd_same", bus.ReadData, 32'h0);
        chk("wr_hit", {31'h0, bus.Hit}, 32'h1);
        @(negedge clk); idle();
        chk("portout", PortOut, 32'hDEADBEEF);
        rd(32'h0, rv); chk("portout_rd", rv, 32'hDEADBEEF);

        // Misaligned store ignored
        @(negedge clk);
        bus.Address = BASE + 32'h2; bus.WriteData = 32'h1111_2222; bus.MemWrite = 1'b1; #1;
        chk("misalign_hit", {31'h0, bus.Hit}, 32'h0);
        @(negedge clk); idle();
        chk("misalign_keep", PortOut, 32'hDEADBEEF);

        // Synchronizer latency and IN_CHG
        PortIn = 8'hA5;
        cyc(1);
        rd(32'h4, rv); chk("pin_e1", rv, 32'h0);
        cyc(1);
        rd(32'h4, rv); chk("pin_e2", rv, 32'h000000A5);
        rd(32'h8, rv); chk("stat_e2", rv, 32'h0);
        cyc(1);
        rd(32'h8, rv); chk("stat_e3", rv, 32'h1);
        chk("irq_no_ie", {31'h0, Irq}, 32'h0);
        wr(32'h10, 32'h2);
        chk("irq_in", {31'h0, Irq}, 32'h1);
        rd(32'h10, rv); chk("ctrl_rd", rv, 32'h2);
        wr(32'h8, 32'h1);
        chk("irq_in_clr", {31'h0, Irq}, 32'h0);
        rd(32'h8, rv); chk("stat_clr", rv, 32'h0);

        // Timer: LOAD=3, enable with IE_TICK
        wr(32'hC, 32'h3);
        rd(32'hC, rv); chk("load_rd", rv, 32'h3);
        rd(32'h14, rv); chk("cnt_idle", rv, 32'h0);
        wr(32'h10, 32'hFFFF_FFFD);
        rd(32'h10, rv); chk("ctrl_upper0", rv, 32'h5);
        rd(32'h14, rv); chk("cnt3", rv, 32'h3);
        chk("irq_t0", {31'h0, Irq}, 32'h0);
        cyc(1); rd(32'h14, rv); chk("cnt2", rv, 32'h2);
        cyc(1); rd(32'h14, rv); chk("cnt1", rv, 32'h1);
        cyc(1); rd(32'h14, rv); chk("cnt0", rv, 32'h0);
        rd(32'h8, rv); chk("tick_pre", rv, 32'h0);
        cyc(1); rd(32'h14, rv); chk("cnt_reload", rv, 32'h3);
        rd(32'h8, rv); chk("tick_set", rv, 32'h2);
        chk("irq_tick", {31'h0, Irq}, 32'h1);
        // Normal W1C at COUNT=3
        wr(32'h8, 32'h2);
        rd(32'h8, rv); chk("tick_clr", rv, 32'h0);
        chk("irq_tick_clr", {31'h0, Irq}, 32'h0);
        rd(32'h14, rv); chk("cnt2b", rv, 32'h2);
        // LOAD write while running leaves COUNT alone
        wr(32'hC, 32'h1);
        rd(32'h14, rv); chk("cnt1b", rv, 32'h1);
        cyc(1); rd(32'h14, rv); chk("cnt0b", rv, 32'h0);
        // W1C in the exact COUNT==0 cycle: set wins; reload uses new LOAD
        wr(32'h8, 32'h2);
        rd(32'h8, rv); chk("tick_set_wins", rv, 32'h2);
        rd(32'h14, rv); chk("cnt_newload", rv, 32'h1);

        // Raise IN_CHG too, then reset over a PORT_OUT write
        PortIn = 8'h3C;
        cyc(3);
        rd(32'h8, rv); chk("both_flags", rv, 32'h3);
        bus.Address = BASE; bus.WriteData = 32'h1234_5678; bus.MemWrite = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; idle();
        chk("rst2_portout", PortOut, 32'h0);
        chk("rst2_irq", {31'h0, Irq}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            rd(32'(i * 4), rv);
            chk($sformatf("rst2_rd%0d", i), rv, 32'h0);
        end
        cyc(1);
        rd(32'h14, rv); chk("rst2_cnt_hold", rv, 32'h0);
        rd(32'h8, rv);  chk("rst2_stat", rv, 32'h0);
        cyc(1);
        rd(32'h4, rv);  chk("rst2_pin", rv, 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
